pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised, registered program-counter unit for the single-cycle/pipelined ARMv8 datapath.
- Holds CurrentPC and computes the next PC for the following instruction classes:
  - sequential
  - conditional branch (CBZ/CBNZ)
  - unconditional branch (B)
  - branch-and-link (BL)
  - return (RET)
- Keeps a small circular return-address stack (RAS) so RET can be resolved without a register-file read.
- Sits between instruction memory addressing and the control unit.

Parameters:
- ADDR_WIDTH, 64: width of the PC, the immediate and the register target.
- INSTR_SHIFT, 2: log2 of instruction size in bytes. Defines the sequential increment (1<<INSTR_SHIFT) and the immediate scaling.
- RAS_DEPTH, 4: number of RAS entries; power of two, ≥2.
- RESET_PC, 0: value loaded into CurrentPC on reset.

Ports:
- CLK  in  1  rising-edge clock
- resetl  in  1  asynchronous, active-low reset
- Stall  in  1  hold PC and RAS this cycle
- Branch  in  1  conditional branch instruction
- BranchNZ  in  1  condition sense: 0 = CBZ (take when ALUZero=1), 1 = CBNZ (take when ALUZero=0)
- ALUZero  in  1  zero flag from ALU
- Uncondbranch  in  1  B/BL
- Link  in  1  BL: push return address (qualified by Uncondbranch)
- Ret  in  1  RET instruction
- SignExtImm64  in  ADDR_WIDTH  sign-extended word offset
- RegTarget  in  ADDR_WIDTH  register value used by RET when RAS is empty
- CurrentPC  out  ADDR_WIDTH  registered PC
- NextPC  out  ADDR_WIDTH  combinational next PC
- LinkAddr  out  ADDR_WIDTH  CurrentPC + (1<<INSTR_SHIFT), for writing X30
- RasEmpty  out  1  RAS count == 0
- RasOverflow  out  1  sticky: a push occurred while the RAS was full
- RasUnderflow  out  1  sticky: a RET occurred while the RAS was empty

Behaviour:
- Reset (resetl=0, asynchronous, immediate):
  - CurrentPC=RESET_PC
  - RAS count=0, top pointer=0, all entries 0
  - RasOverflow=0, RasUnderflow=0
  - RasEmpty=1 follows combinationally
- Sequential PC: SeqPC = CurrentPC + (1<<INSTR_SHIFT).
- Branch target: BrPC = CurrentPC + (SignExtImm64 << INSTR_SHIFT).
- Arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- NextPC selection, in priority order (purely combinational, zero latency):
  1. Ret=1: NextPC = RAS top if count>0, else RegTarget.
  2. Uncondbranch=1: NextPC = BrPC.
  3. Branch=1 and (ALUZero XOR BranchNZ)=1: NextPC = BrPC.
  4. Otherwise: NextPC = SeqPC.
- On each rising CLK with Stall=0: CurrentPC <= NextPC. With Stall=1: CurrentPC, RAS and sticky flags hold. NextPC still reflects the current inputs.
- Push (Uncondbranch=1, Link=1, Ret=0, Stall=0):
  - top pointer advances modulo RAS_DEPTH; entry written with LinkAddr.
  - count increments, saturating at RAS_DEPTH.
  - if count was already RAS_DEPTH, the oldest entry is overwritten and RasOverflow is set.
- Pop (Ret=1, Stall=0, count>0): top pointer retreats modulo RAS_DEPTH; count decrements.
- Ret with count=0: no pointer change; RasUnderflow set.
- Ret=1 together with Link=1 and Uncondbranch=1:
  - Ret wins the target.
  - Top entry is replaced with LinkAddr; pointer and count unchanged.
  - If count=0, the entry is pushed instead (count becomes 1) and RasUnderflow is still set.
- Link=1 without Uncondbranch: ignored.
- Branch and Uncondbranch both 1: Uncondbranch wins (same target; no conflict).
- Sticky flags clear only on reset.
- Reset asserted mid-cycle overrides all inputs; Stall has no effect during reset.

Decomposition:
- Shared package pc_pkg: RAS_DEPTH/INSTR_SHIFT defaults, next-PC source enum (SRC_SEQ, SRC_BR, SRC_RAS, SRC_REG).
- One sub-module: ras_stack (circular buffer with push/pop/replace, count, pointer, overflow/underflow flags).
- Next-PC mux and PC register stay in pc_sequencer.

Test Plan:
- Reset with RESET_PC=0, then 3 clocks with no control inputs → CurrentPC 0,4,8,12; RasEmpty=1.
- CurrentPC=16; Branch=1, BranchNZ=0, ALUZero=1, imm=2 → NextPC=24. Repeat with ALUZero=0 → 20. Repeat with BranchNZ=1, ALUZero=0 → 24.
- CurrentPC=16, Uncondbranch=1, Link=1, imm=4 → NextPC=32, LinkAddr=20. Then Ret=1 with RegTarget=0x999 → NextPC=20; RasEmpty=1 after the edge.
- Five BLs with RAS_DEPTH=4 from PCs 0x100, 0x200, 0x300, 0x400, 0x500:
  - RasOverflow=1 after the 5th push.
  - Four RETs return 0x504, 0x404, 0x304, 0x204.
  - A fifth RET with RegTarget=0x40 → NextPC=0x40, RasUnderflow=1.
- Stall=1 with Uncondbranch=1, Link=1 across 3 edges → CurrentPC and RAS count unchanged; NextPC still shows the target.
- CurrentPC=0xFFFF_FFFF_FFFF_FFFC, sequential → NextPC=0. Assert resetl=0 mid-cycle after two pushes → CurrentPC=RESET_PC, RasEmpty=1, both sticky flags 0 immediately, before the next clock.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
package pc_pkg;

  localparam int DEF_RAS_DEPTH   = 4;
  localparam int DEF_INSTR_SHIFT = 2;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_RAS,
    SRC_REG
  } pcSrc_e;

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack with push, pop, replace and sticky error flags.
module ras_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = DEF_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             stall,
  input  logic             doRet,
  input  logic             doLink,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptrInc;
  logic [PW-1:0]    ptrDec;
  logic [CW-1:0]    count;
  logic             full;

  assign ptrInc = ptr + PW'(1);
  assign ptrDec = ptr - PW'(1);
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign top    = entries[ptr];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!stall) begin
      if (doRet && doLink) begin
        // RET+BL: an empty stack turns the replace into a push
        if (empty) begin
          ptr             <= ptrInc;
          entries[ptrInc] <= pushData;
          count           <= CW'(1);
          underflow       <= 1'b1;
        end else begin
          entries[ptr] <= pushData;
        end
      end else if (doRet) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          ptr   <= ptrDec;
          count <= count - CW'(1);
        end
      end else if (doLink) begin
        ptr             <= ptrInc;
        entries[ptrInc] <= pushData;
        if (full) overflow <= 1'b1;
        else      count    <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered PC with next-PC selection and a return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              ADDR_WIDTH  = 64,
  parameter int              INSTR_SHIFT = DEF_INSTR_SHIFT,
  parameter int              RAS_DEPTH   = DEF_RAS_DEPTH,
  parameter [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  CLK,
  input  logic                  resetl,
  input  logic                  Stall,
  input  logic                  Branch,
  input  logic                  BranchNZ,
  input  logic                  ALUZero,
  input  logic                  Uncondbranch,
  input  logic                  Link,
  input  logic                  Ret,
  input  logic [ADDR_WIDTH-1:0] SignExtImm64,
  input  logic [ADDR_WIDTH-1:0] RegTarget,
  output logic [ADDR_WIDTH-1:0] CurrentPC,
  output logic [ADDR_WIDTH-1:0] NextPC,
  output logic [ADDR_WIDTH-1:0] LinkAddr,
  output logic                  RasEmpty,
  output logic                  RasOverflow,
  output logic                  RasUnderflow
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(1) << INSTR_SHIFT;

  logic [ADDR_WIDTH-1:0] seqPc;
  logic [ADDR_WIDTH-1:0] brPc;
  logic [ADDR_WIDTH-1:0] rasTop;
  pcSrc_e                src;

  assign seqPc    = CurrentPC + STEP;
  assign brPc     = CurrentPC + (SignExtImm64 << INSTR_SHIFT);
  assign LinkAddr = seqPc;

  always_comb begin
    src = SRC_SEQ;
    if (Ret)                               src = RasEmpty ? SRC_REG : SRC_RAS;
    else if (Uncondbranch)                 src = SRC_BR;
    else if (Branch && (ALUZero ^ BranchNZ)) src = SRC_BR;
  end

  always_comb begin
    unique case (src)
      SRC_BR:  NextPC = brPc;
      SRC_RAS: NextPC = rasTop;
      SRC_REG: NextPC = RegTarget;
      default: NextPC = seqPc;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl)     CurrentPC <= RESET_PC;
    else if (!Stall) CurrentPC <= NextPC;
  end

  ras_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) uRas (
    .clk       (CLK),
    .rstN      (resetl),
    .stall     (Stall),
    .doRet     (Ret),
    .doLink    (Uncondbranch & Link),
    .pushData  (LinkAddr),
    .top       (rasTop),
    .empty     (RasEmpty),
    .overflow  (RasOverflow),
    .underflow (RasUnderflow)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        Stall, Branch, BranchNZ, ALUZero;
  logic        Uncondbranch, Link, Ret;
  logic [63:0] SignExtImm64, RegTarget;
  logic [63:0] CurrentPC, NextPC, LinkAddr;
  logic        RasEmpty, RasOverflow, RasUnderflow;

  int nChk = 0;
  int nBad = 0;
  logic [63:0] expPc;

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK          (CLK),
    .resetl       (resetl),
    .Stall        (Stall),
    .Branch       (Branch),
    .BranchNZ     (BranchNZ),
    .ALUZero      (ALUZero),
    .Uncondbranch (Uncondbranch),
    .Link         (Link),
    .Ret          (Ret),
    .SignExtImm64 (SignExtImm64),
    .RegTarget    (RegTarget),
    .CurrentPC    (CurrentPC),
    .NextPC       (NextPC),
    .LinkAddr     (LinkAddr),
    .RasEmpty     (RasEmpty),
    .RasOverflow  (RasOverflow),
    .RasUnderflow (RasUnderflow)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    Stall = 0; Branch = 0; BranchNZ = 0; ALUZero = 0;
    Uncondbranch = 0; Link = 0; Ret = 0;
    SignExtImm64 = '0; RegTarget = '0;
  endtask

  task automatic step(input string tag, input logic [63:0] want);
    @(posedge CLK);
    #1;
    expPc = want;
    chk(tag, CurrentPC, want);
  endtask

  task automatic jumpTo(input logic [63:0] addr);
    idle();
    Uncondbranch = 1;
    SignExtImm64 = (addr - expPc) >> 2;
    step("jump", addr);
    idle();
  endtask

  initial begin
    idle();
    resetl = 0;
    expPc  = '0;
    #3;
    chk("rst_pc", CurrentPC, 64'd0);
    chk("rst_empty", {63'd0, RasEmpty}, 64'd1);
    chk("rst_ovf", {63'd0, RasOverflow}, 64'd0);
    chk("rst_unf", {63'd0, RasUnderflow}, 64'd0);
    @(posedge CLK);
    #1 resetl = 1;
    chk("seq0", CurrentPC, 64'd0);
    step("seq4", 64'd4);
    step("seq8", 64'd8);
    step("seq12", 64'd12);
    chk("seq_empty", {63'd0, RasEmpty}, 64'd1);

    jumpTo(64'd16);
    Branch = 1; BranchNZ = 0; ALUZero = 1; SignExtImm64 = 64'd2;
    #1 chk("cbz_taken", NextPC, 64'd24);
    ALUZero = 0;
    #1 chk("cbz_not", NextPC, 64'd20);
    BranchNZ = 1;
    #1 chk("cbnz_taken", NextPC, 64'd24);
    idle();

    Uncondbranch = 1; Link = 1; SignExtImm64 = 64'd4;
    #1 chk("bl_target", NextPC, 64'd32);
    chk("bl_link", LinkAddr, 64'd20);
    step("bl_pc", 64'd32);
    chk("bl_nonempty", {63'd0, RasEmpty}, 64'd0);
    idle();
    Ret = 1; RegTarget = 64'h999;
    #1 chk("ret_ras", NextPC, 64'd20);
    step("ret_pc", 64'd20);
    chk("ret_empty", {63'd0, RasEmpty}, 64'd1);
    idle();

    jumpTo(64'h100);
    for (int i = 1; i <= 5; i++) begin
      Uncondbranch = 1; Link = 1; SignExtImm64 = 64'h40;
      if (i == 5) chk("pre_ovf", {63'd0, RasOverflow}, 64'd0);
      step("bl_chain", 64'(i + 1) << 8);
    end
    chk("ovf_set", {63'd0, RasOverflow}, 64'd1);
    idle();
    for (int i = 5; i >= 2; i--) begin
      Ret = 1; RegTarget = 64'h40;
      #1 chk("ret_chain", NextPC, (64'(i) << 8) + 64'h4);
      step("ret_chain_pc", (64'(i) << 8) + 64'h4);
    end
    chk("unf_clear", {63'd0, RasUnderflow}, 64'd0);
    #1 chk("ret_reg", NextPC, 64'h40);
    step("ret_reg_pc", 64'h40);
    chk("unf_set", {63'd0, RasUnderflow}, 64'd1);
    idle();

    Stall = 1; Uncondbranch = 1; Link = 1; SignExtImm64 = 64'd4;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_next", NextPC, 64'h50);
      step("stall_pc", 64'h40);
      chk("stall_empty", {63'd0, RasEmpty}, 64'd1);
    end
    idle();

    jumpTo(64'hFFFF_FFFF_FFFF_FFFC);
    #1 chk("wrap_next", NextPC, 64'd0);
    step("wrap_pc", 64'd0);
    Uncondbranch = 1; Link = 1; SignExtImm64 = 64'd8;
    step("push1", 64'h20);
    step("push2", 64'h40);
    idle();
    chk("pre_rst_empty", {63'd0, RasEmpty}, 64'd0);
    Stall = 1;
    #2 resetl = 0;
    #1;
    chk("mid_rst_pc", CurrentPC, 64'd0);
    chk("mid_rst_empty", {63'd0, RasEmpty}, 64'd1);
    chk("mid_rst_ovf", {63'd0, RasOverflow}, 64'd0);
    chk("mid_rst_unf", {63'd0, RasUnderflow}, 64'd0);
    #10;
    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end

endmodule
